pao_reader: RTL and testbench

Byte-program loader and execution core for small test programs. Sits between a byte-wide program source (file image or host) and debug/observation logic. While `run` is low it copies bytes into a 256-byte internal program memory. Once `run` rises it executes the stored variable-length program on four 32-bit registers, exposing the instruction pointer, current opcode, r0, r1 and a debug word.

---
 rtl/pao_reader_pkg.sv | 42 ++++
 rtl/pao_alu.sv | 23 ++
 rtl/pao_reader.sv | 128 ++++++++++++
 tb/tb_pao_reader.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pao_reader_pkg.sv
// Shared definitions for the pao_reader byte-program core: opcodes,
// instruction lengths, FSM state encoding and ALU operation select.
package pao_reader_pkg;

    // Opcode values of the supported instruction set
    localparam logic [7:0] OP_NOP  = 8'h00;
    localparam logic [7:0] OP_MOV  = 8'h01;
    localparam logic [7:0] OP_ADD  = 8'h02;
    localparam logic [7:0] OP_SUB  = 8'h03;
    localparam logic [7:0] OP_JMP  = 8'h04;
    localparam logic [7:0] OP_JNZ  = 8'h05;
    localparam logic [7:0] OP_INC  = 8'h06;
    localparam logic [7:0] OP_HALT = 8'hFF;

    // Instruction lengths in bytes, sized to add directly onto the pointer
    localparam logic [7:0] LEN_1 = 8'd1;
    localparam logic [7:0] LEN_2 = 8'd2;
    localparam logic [7:0] LEN_3 = 8'd3;

    // Saturation limit of the retired-instruction counter
    localparam logic [15:0] RETIRED_MAX = 16'hFFFF;

    // State encoding doubles as the debug state code
    typedef enum logic [1:0] {
        ST_LOAD  = 2'd0,
        ST_FETCH = 2'd1,
        ST_EXEC  = 2'd2,
        ST_HALT  = 2'd3
    } state_e;

    typedef enum logic [1:0] {
        ALU_ADD = 2'd0,
        ALU_SUB = 2'd1,
        ALU_INC = 2'd2
    } alu_op_e;

    // Widen a state to the 8-bit code reported in debug[31:24]
    function automatic logic [7:0] state_code(input state_e s);
        return {6'd0, s};
    endfunction

endpackage

// File: rtl/pao_alu.sv
// Combinational 32-bit arithmetic unit for ADD, SUB and INC.
module pao_alu
    import pao_reader_pkg::*;
(
    input  alu_op_e     op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] result
);

    // Select the arithmetic result; all operations wrap mod 2^32
    always_comb begin
        // NOTE: default assignment first so no path through the block leaves result unassigned (no latch).
        result = a + b;
        case (op)
            ALU_ADD: result = a + b;
            ALU_SUB: result = a - b;
            ALU_INC: result = a + 32'd1;
            default: result = a + b;
        endcase
    end

endmodule

// File: rtl/pao_reader.sv
// Byte-program loader and two-cycle-per-instruction execution core.
// Loads a 256-byte program while run is low, then executes it on a
// 4 x 32-bit register file until a HALT instruction or reset.
module pao_reader
    import pao_reader_pkg::*;
(
    output logic [7:0]  iPointer,
    output logic [7:0]  opCode,
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] r0,
    output logic [31:0] r1,
    output logic [31:0] debug,
    input  logic [7:0]  ramAddress,
    input  logic [7:0]  ramValue,
    input  logic        run
);

    logic [7:0]  mem [256];
    logic [31:0] regs [4];
    state_e      state;
    logic [7:0]  last_illegal;
    logic [15:0] retired;

    logic [7:0]  addr1;
    logic [7:0]  addr2;
    logic [7:0]  b1;
    logic [7:0]  b2;
    logic [1:0]  rd_idx;
    logic [1:0]  rs_idx;
    alu_op_e     alu_op;
    logic [31:0] alu_result;

    // Operand bytes follow the opcode; 8-bit sums wrap around the memory
    assign addr1  = iPointer + LEN_1;
    assign addr2  = iPointer + LEN_2;
    assign b1     = mem[addr1];
    assign b2     = mem[addr2];
    assign rd_idx = b1[1:0];
    assign rs_idx = b2[1:0];

    // Map the latched opcode onto an ALU operation
    always_comb begin
        alu_op = ALU_ADD;
        case (opCode)
            OP_SUB:  alu_op = ALU_SUB;
            OP_INC:  alu_op = ALU_INC;
            default: alu_op = ALU_ADD;
        endcase
    end

    pao_alu u_alu (
        .op     (alu_op),
        .a      (regs[rd_idx]),
        .b      (regs[rs_idx]),
        .result (alu_result)
    );

    // Program memory write port, open only in LOAD while run is low
    // NOTE: the memory array is deliberately not reset; its contents must survive reset, and a reset-free array maps onto RAM.
    always_ff @(posedge clk) begin
        if (!reset && state == ST_LOAD && !run) begin
            mem[ramAddress] <= ramValue;
        end
    end

    // Control FSM: load, fetch, execute and halt, with registered outputs
    // NOTE: non-blocking assignments so every branch reads the pre-edge values of the state it updates.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= ST_LOAD;
            iPointer     <= '0;
            opCode       <= '0;
            last_illegal <= '0;
            retired      <= '0;
            for (int i = 0; i < 4; i++) begin
                regs[i] <= '0;
            end
        end else begin
            case (state)
                ST_LOAD: begin
                    if (run) begin
                        state <= ST_FETCH;
                    end
                end
                ST_FETCH: begin
                    opCode <= mem[iPointer];
                    state  <= ST_EXEC;
                end
                ST_EXEC: begin
                    state <= ST_FETCH;
                    if (retired != RETIRED_MAX) begin
                        retired <= retired + 16'd1;
                    end
                    case (opCode)
                        OP_NOP: iPointer <= iPointer + LEN_1;
                        OP_MOV: begin
                            regs[rd_idx] <= {24'd0, b2};
                            iPointer     <= iPointer + LEN_3;
                        end
                        OP_ADD, OP_SUB: begin
                            regs[rd_idx] <= alu_result;
                            iPointer     <= iPointer + LEN_3;
                        end
                        OP_JMP: iPointer <= b1;
                        OP_JNZ: iPointer <= (regs[rd_idx] != '0) ? b2 : iPointer + LEN_3;
                        OP_INC: begin
                            regs[rd_idx] <= alu_result;
                            iPointer     <= iPointer + LEN_2;
                        end
                        OP_HALT: state <= ST_HALT;
                        default: begin
                            last_illegal <= opCode;
                            iPointer     <= iPointer + LEN_1;
                        end
                    endcase
                end
                ST_HALT: state <= ST_HALT;
                default: state <= ST_LOAD;
            endcase
        end
    end

    assign r0    = regs[0];
    assign r1    = regs[1];
    assign debug = {state_code(state), last_illegal, retired};

endmodule

// File: tb/tb_pao_reader.sv
// Self-checking bench for pao_reader: directed programs with hand-computed
// results plus random programs checked against an instruction-level model.
// Expected final states go into a scoreboard queue; a monitor pops and
// compares each time the core enters HALT.
module tb_pao_reader;

    logic        clk;
    logic        reset;
    logic [7:0]  iPointer;
    logic [7:0]  opCode;
    logic [31:0] r0;
    logic [31:0] r1;
    logic [31:0] debug;
    logic [7:0]  ramAddress;
    logic [7:0]  ramValue;
    logic        run;

    typedef struct {
        string       name;
        logic [31:0] r0;
        logic [31:0] r1;
        logic [7:0]  ip;
        logic [7:0]  op;
        logic [31:0] debug;
    } exp_t;

    exp_t       sb[$];
    int         checks = 0;
    int         failures = 0;
    int         halt_events = 0;
    logic [7:0] img [256];

    pao_reader dut (
        .iPointer   (iPointer),
        .opCode     (opCode),
        .clk        (clk),
        .reset      (reset),
        .r0         (r0),
        .r1         (r1),
        .debug      (debug),
        .ramAddress (ramAddress),
        .ramValue   (ramValue),
        .run        (run)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    function automatic exp_t mk(input string n, input logic [31:0] r0v, input logic [31:0] r1v,
                                input logic [7:0] ipv, input logic [7:0] opv, input logic [31:0] dbg);
        exp_t e;
        e.name = n; e.r0 = r0v; e.r1 = r1v; e.ip = ipv; e.op = opv; e.debug = dbg;
        return e;
    endfunction

    // Instruction-level reference: interprets the program image directly
    task automatic model(input logic [7:0] m [256], output exp_t e, output bit halted, output int steps);
        int unsigned r [4];
        int          ip;
        logic [7:0]  op, b1, b2, ill;
        for (int i = 0; i < 4; i++) r[i] = 0;
        ip = 0; op = 8'h00; ill = 8'h00; halted = 0; steps = 0;
        while (!halted && steps < 200) begin
            op = m[ip];
            b1 = m[(ip + 1) % 256];
            b2 = m[(ip + 2) % 256];
            steps++;
            case (op)
                8'h00: ip = ip + 1;
                8'h01: begin r[b1[1:0]] = {24'd0, b2}; ip = ip + 3; end
                8'h02: begin r[b1[1:0]] = r[b1[1:0]] + r[b2[1:0]]; ip = ip + 3; end
                8'h03: begin r[b1[1:0]] = r[b1[1:0]] - r[b2[1:0]]; ip = ip + 3; end
                8'h04: ip = b1;
                8'h05: ip = (r[b1[1:0]] != 0) ? int'(b2) : ip + 3;
                8'h06: begin r[b1[1:0]] = r[b1[1:0]] + 1; ip = ip + 2; end
                8'hFF: halted = 1;
                default: begin ill = op; ip = ip + 1; end
            endcase
            ip = ip % 256;
        end
        e.name  = "model";
        e.r0    = r[0];
        e.r1    = r[1];
        e.ip    = 8'(ip);
        e.op    = op;
        e.debug = {8'd3, ill, 16'(steps)};
    endtask

    // Monitor: on entry to HALT, pop the expected final state and compare
    bit   prev_halt = 1'b0;
    bit   cur_halt;
    exp_t mon_e;
    always @(negedge clk) begin
        cur_halt = (debug[31:24] == 8'd3);
        if (cur_halt && !prev_halt) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_halt actual=halt expected=no_halt");
            end else begin
                mon_e = sb.pop_front();
                check({mon_e.name, "_r0"},    r0,       mon_e.r0);
                check({mon_e.name, "_r1"},    r1,       mon_e.r1);
                check({mon_e.name, "_ip"},    {24'd0, iPointer}, {24'd0, mon_e.ip});
                check({mon_e.name, "_op"},    {24'd0, opCode},   {24'd0, mon_e.op});
                check({mon_e.name, "_debug"}, debug,    mon_e.debug);
            end
            halt_events++;
        end
        prev_halt = cur_halt;
    end

    task automatic check_zero(input string tag);
        check({tag, "_ip"},    {24'd0, iPointer}, 32'd0);
        check({tag, "_op"},    {24'd0, opCode},   32'd0);
        check({tag, "_r0"},    r0,    32'd0);
        check({tag, "_r1"},    r1,    32'd0);
        check({tag, "_debug"}, debug, 32'd0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        run   = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic clear_img();
        for (int a = 0; a < 256; a++) img[a] = 8'h00;
    endtask

    task automatic load_image();
        run = 1'b0;
        for (int a = 0; a < 256; a++) begin
            ramAddress = 8'(a);
            ramValue   = img[a];
            @(negedge clk);
        end
    endtask

    // Raise run, push the expectation and wait (bounded) for the HALT event
    task automatic run_and_wait(input exp_t e, input int budget, input bit disturb, input bit timeline);
        int start;
        bit got;
        start = halt_events;
        got   = 1'b0;
        sb.push_back(e);
        run = 1'b1;
        for (int c = 0; c < budget; c++) begin
            @(negedge clk);
            if (timeline && c == 0) check("tl_state_fetch", {24'd0, debug[31:24]}, 32'd1);
            if (timeline && c == 1) begin
                check("tl_opcode", {24'd0, opCode}, 32'h01);
                check("tl_state_exec", {24'd0, debug[31:24]}, 32'd2);
            end
            if (timeline && c == 2) check("tl_r0_first", r0, 32'd5);
            if (halt_events != start) begin
                got = 1'b1;
                break;
            end
            if (disturb) begin
                run        = 1'($urandom_range(0, 1));
                ramAddress = 8'($urandom);
                ramValue   = 8'($urandom);
            end
        end
        check({e.name, "_halt_reached"}, {31'd0, got}, 32'd1);
        if (!got) sb.delete();
        run = 1'b0;
    endtask

    task automatic gen_random(output exp_t e, output int steps);
        bit ok;
        int pick;
        ok = 1'b0;
        for (int t = 0; t < 100 && !ok; t++) begin
            for (int a = 0; a < 256; a++) begin
                pick = $urandom_range(0, 99);
                if (pick < 55)      img[a] = 8'($urandom_range(0, 6));
                else if (pick < 62) img[a] = 8'hFF;
                else                img[a] = 8'($urandom);
            end
            model(img, e, ok, steps);
        end
        if (!ok) begin
            img[0] = 8'hFF;
            model(img, e, ok, steps);
        end
    endtask

    exp_t loop_exp;

    initial begin
        exp_t re;
        int   st;
        reset = 1'b1; run = 1'b0; ramAddress = 8'h00; ramValue = 8'h00;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        check_zero("reset");

        // MOV r0,5 / MOV r1,3 / ADD r0,r1 / HALT with first-instruction timeline
        clear_img();
        img[0] = 8'h01; img[1] = 8'h00; img[2] = 8'h05;
        img[3] = 8'h01; img[4] = 8'h01; img[5] = 8'h03;
        img[6] = 8'h02; img[7] = 8'h00; img[8] = 8'h01;
        img[9] = 8'hFF;
        load_image();
        run_and_wait(mk("add", 32'd8, 32'd3, 8'd9, 8'hFF, 32'h03000004), 100, 1'b0, 1'b1);

        // Countdown loop: MOV r1,3 / MOV r2,1 / SUB r1,r2 / JNZ r1,6 / HALT
        do_reset();
        clear_img();
        img[0]  = 8'h01; img[1]  = 8'h01; img[2]  = 8'h03;
        img[3]  = 8'h01; img[4]  = 8'h02; img[5]  = 8'h01;
        img[6]  = 8'h03; img[7]  = 8'h01; img[8]  = 8'h02;
        img[9]  = 8'h05; img[10] = 8'h01; img[11] = 8'h06;
        img[12] = 8'hFF;
        load_image();
        loop_exp = mk("loop", 32'd0, 32'd0, 8'd12, 8'hFF, 32'h03000009);
        run_and_wait(loop_exp, 100, 1'b0, 1'b0);

        // Reset with run high, then reset with a pending write to address 0
        reset = 1'b1; run = 1'b1;
        @(negedge clk);
        run = 1'b0; ramAddress = 8'h00; ramValue = 8'hAA;
        @(negedge clk);
        reset = 1'b0;
        check_zero("reset_run");
        loop_exp.name = "loop_rerun";
        run_and_wait(loop_exp, 100, 1'b0, 1'b0);

        // Reset in the middle of execution, then rerun with bus disturbance
        reset = 1'b1; run = 1'b0;
        @(negedge clk);
        reset = 1'b0; run = 1'b1;
        repeat (7) @(negedge clk);
        reset = 1'b1; run = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        check_zero("mid_reset");
        loop_exp.name = "loop_disturbed";
        run_and_wait(loop_exp, 100, 1'b1, 1'b0);

        // Illegal opcode followed by HALT
        do_reset();
        clear_img();
        img[0] = 8'h7E; img[1] = 8'hFF;
        load_image();
        run_and_wait(mk("illegal", 32'd0, 32'd0, 8'd1, 8'hFF, 32'h037E0002), 100, 1'b0, 1'b0);

        // Wrap: INC at 0xFE reads its operand from 0xFF and falls through to 0x00
        do_reset();
        clear_img();
        img[0] = 8'h05; img[1] = 8'h00; img[2] = 8'h10;
        img[3] = 8'h04; img[4] = 8'hFE;
        img[8'hFE] = 8'h06; img[8'hFF] = 8'h00;
        img[8'h10] = 8'hFF;
        load_image();
        run_and_wait(mk("wrap_inc", 32'd1, 32'd0, 8'h10, 8'hFF, 32'h03000005), 100, 1'b0, 1'b0);

        // Wrap: 3-byte MOV at 0xFE takes its immediate from address 0x00
        do_reset();
        clear_img();
        img[0] = 8'h04; img[1] = 8'hFE; img[2] = 8'hFF;
        img[8'hFE] = 8'h01; img[8'hFF] = 8'h01;
        load_image();
        run_and_wait(mk("wrap_mov", 32'd0, 32'd4, 8'd2, 8'hFF, 32'h03FE0004), 100, 1'b0, 1'b0);

        // Random programs against the reference model, with bus disturbance
        for (int i = 0; i < 20; i++) begin
            do_reset();
            gen_random(re, st);
            re.name = $sformatf("rand%0d", i);
            load_image();
            run_and_wait(re, 2 * st + 20, 1'b1, 1'b0);
        end

        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
